// File: rtl/census_transform_pkg.sv
// Shared census/window geometry helpers: bit count, pixel offset in a packed window, centre position.
package census_transform_pkg;

  function automatic int unsigned census_bits(input int unsigned ww, input int unsigned nl);
    return ww * nl - 1;
  endfunction

  // Bit offset of pixel (r,c) inside a packed window; r=0 oldest line, c=0 oldest column.
  function automatic int unsigned pix_offset(input int unsigned r, input int unsigned c,
                                             input int unsigned ww, input int unsigned w);
    return (r * ww + c) * w;
  endfunction

  function automatic int unsigned centre_row(input int unsigned nl);
    return nl / 2;
  endfunction

  function automatic int unsigned centre_col(input int unsigned ww);
    return ww / 2;
  endfunction

endpackage

// File: rtl/census_transform_window_pos.sv
// Tracks the (col,row) position of each accepted pixel and flags windows that are not fully populated.
module window_pos_counter #(
  parameter int unsigned LINE_LENGTH  = 640,
  parameter int unsigned NUM_ROWS     = 480,
  parameter int unsigned WINDOW_WIDTH = 5,
  parameter int unsigned NUM_LINES    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_sof,
  output logic border_c
);

  localparam int unsigned COL_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;

  // col_q/row_q hold the position of the next pixel; sof forces the current one to (0,0).
  always_comb begin
    cur_col = in_sof ? '0 : col_q;
    cur_row = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (cur_col == COL_W'(LINE_LENGTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == ROW_W'(NUM_ROWS - 1)) ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
    end
    border_c = (cur_col < COL_W'(WINDOW_WIDTH - 1)) || (cur_row < ROW_W'(NUM_LINES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/census_transform.sv
// Census transform: one bit per neighbour set when darker than the window centre, 2-cycle latency,
// zeroed and flagged for windows overlapping the top/left image border.
module census_transform
  import census_transform_pkg::*;
#(
  parameter  int unsigned WIDTH        = 8,
  parameter  int unsigned WINDOW_WIDTH = 5,
  parameter  int unsigned NUM_LINES    = 5,
  parameter  int unsigned LINE_LENGTH  = 640,
  parameter  int unsigned NUM_ROWS     = 480,
  localparam int unsigned CENSUS_BITS  = census_bits(WINDOW_WIDTH, NUM_LINES),
  localparam int unsigned WIN_W        = WIDTH * WINDOW_WIDTH * NUM_LINES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [WIN_W-1:0]       window,
  output logic                   out_valid,
  output logic                   out_border,
  output logic [CENSUS_BITS-1:0] census
);

  localparam int unsigned CTR_R   = centre_row(NUM_LINES);
  localparam int unsigned CTR_C   = centre_col(WINDOW_WIDTH);
  localparam int unsigned CTR_IDX = CTR_R * WINDOW_WIDTH + CTR_C;
  localparam int unsigned CTR_OFF = pix_offset(CTR_R, CTR_C, WINDOW_WIDTH, WIDTH);

  logic                   border_c;
  logic [WIN_W-1:0]       win_q, win_d;
  logic                   border1_q, border1_d;
  logic                   valid1_q, valid1_d;
  logic [CENSUS_BITS-1:0] census_q, census_d;
  logic                   border_q, border_d;
  logic                   valid_q, valid_d;
  logic [CENSUS_BITS-1:0] cmp_c;
  logic [WIDTH-1:0]       centre_c;

  window_pos_counter #(
    .LINE_LENGTH  (LINE_LENGTH),
    .NUM_ROWS     (NUM_ROWS),
    .WINDOW_WIDTH (WINDOW_WIDTH),
    .NUM_LINES    (NUM_LINES)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .border_c (border_c)
  );

  assign centre_c = win_q[CTR_OFF +: WIDTH];

  // Census bit k walks the window in raster order, skipping the centre pixel.
  for (genvar k = 0; k < CENSUS_BITS; k++) begin : g_cmp
    localparam int unsigned K   = k;
    localparam int unsigned IDX = (K < CTR_IDX) ? K : K + 1;
    localparam int unsigned OFF = pix_offset(IDX / WINDOW_WIDTH, IDX % WINDOW_WIDTH,
                                             WINDOW_WIDTH, WIDTH);
    assign cmp_c[k] = (win_q[OFF +: WIDTH] < centre_c);
  end

  // Data registers only load on valid so outputs hold their last value across bubbles.
  always_comb begin
    win_d     = win_q;
    border1_d = border1_q;
    valid1_d  = in_valid;
    census_d  = census_q;
    border_d  = border_q;
    valid_d   = valid1_q;
    if (in_valid) begin
      win_d     = window;
      border1_d = border_c;
    end
    if (valid1_q) begin
      border_d = border1_q;
      census_d = border1_q ? '0 : cmp_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q     <= '0;
      border1_q <= 1'b0;
      valid1_q  <= 1'b0;
      census_q  <= '0;
      border_q  <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      win_q     <= win_d;
      border1_q <= border1_d;
      valid1_q  <= valid1_d;
      census_q  <= census_d;
      border_q  <= border_d;
      valid_q   <= valid_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_border = border_q;
  assign census     = census_q;

endmodule
